// File: rtl/seq_div_16b.sv
// rtl/seq_div_16b.sv - multi-cycle radix-2 restoring unsigned divider
module seq_div_16b #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    // While iterations remain, the partial remainder is the running modulus of
    // at most WIDTH-1 dividend bits, so it always fits in WIDTH-1 bits. Only the
    // final iteration can produce a full-width remainder, and that one goes
    // straight to the result register.
    logic [WIDTH-2:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // One restoring step: shift {r,q} left, trial-subtract, keep or restore.
    always_comb begin
        r_shift = {rem_q, quo_q[WIDTH-1]};
        q_shift = {quo_q[WIDTH-2:0], 1'b0};
        trial   = {1'b0, r_shift} - {1'b0, divisor_q};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = q_shift | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            rem_next = r_shift;
            quo_next = q_shift;
        end
    end

    // Next-state and datapath load/iterate decisions.
    always_comb begin
        state_d     = state_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (divisor == '0) begin
                        // Flag and finish at once; no iterations are run.
                        state_d     = S_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d   = S_RUN;
                        divisor_d = divisor;
                        rem_d     = '0;
                        quo_d     = dividend;
                        count_d   = CW'(WIDTH);
                        dbz_d     = 1'b0;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // start is deliberately ignored while iterating.
                rem_d   = rem_next[WIDTH-2:0];
                quo_d   = quo_next;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d     = S_DONE;
                    quotient_d  = quo_next;
                    remainder_d = rem_next;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_16b.sv
// tb/tb_seq_div_16b.sv - randomized self-checking bench for seq_div_16b
module tb_seq_div_16b;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int pass_cnt;
    int total_cnt;

    seq_div_16b #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer division, zero divisor yields all-ones / dividend.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic z, output int lat);
        int unsigned ua;
        int unsigned ub;
        ua = a;
        ub = b;
        if (ub == 0) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
            lat = 1;
        end else begin
            q = 16'(ua / ub);
            r = 16'(ua % ub);
            z = 1'b0;
            lat = 17;
        end
    endfunction

    // Issue one operation and wait for done; edges counts the start edge as 1.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output int edges, output int busy_cycles);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        edges = 1;
        busy_cycles = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else pass_cnt++;
        total_cnt++; if (quotient !== 16'h0) $display("FAIL reset_quotient got %h want 0000", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 16'h0) $display("FAIL reset_remainder got %h want 0000", remainder); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %0b want 0", div_by_zero); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int edges;
        int bc;
        run_op(16'd100, 16'd7, edges, bc);
        total_cnt++; if (edges !== 17) $display("FAIL basic_latency got %0d want 17", edges); else pass_cnt++;
        total_cnt++; if (bc !== 16) $display("FAIL basic_busy_cycles got %0d want 16", bc); else pass_cnt++;
        total_cnt++; if (quotient !== 16'd14) $display("FAIL basic_quotient got %0d want 14", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 16'd2) $display("FAIL basic_remainder got %0d want 2", remainder); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL basic_dbz got %0b want 0", div_by_zero); else pass_cnt++;
    endtask

    task automatic test_full_range();
        logic [15:0] av [3];
        logic [15:0] bv [3];
        logic [15:0] qv [3];
        logic [15:0] rv [3];
        int edges;
        int bc;
        av = '{16'hFFFF, 16'd3, 16'h8000};
        bv = '{16'h0001, 16'd10, 16'hFFFF};
        qv = '{16'hFFFF, 16'd0, 16'd0};
        rv = '{16'h0000, 16'd3, 16'h8000};
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], edges, bc);
            total_cnt++; if (edges !== 17) $display("FAIL range%0d_latency got %0d want 17", i, edges); else pass_cnt++;
            total_cnt++; if (quotient !== qv[i]) $display("FAIL range%0d_quotient got %h want %h", i, quotient, qv[i]); else pass_cnt++;
            total_cnt++; if (remainder !== rv[i]) $display("FAIL range%0d_remainder got %h want %h", i, remainder, rv[i]); else pass_cnt++;
        end
    endtask

    task automatic test_div_zero();
        int edges;
        int bc;
        run_op(16'h1234, 16'h0000, edges, bc);
        total_cnt++; if (edges !== 1) $display("FAIL dbz_latency got %0d want 1", edges); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || bc !== 0) $display("FAIL dbz_busy got %0b/%0d want 0/0", busy, bc); else pass_cnt++;
        total_cnt++; if (quotient !== 16'hFFFF) $display("FAIL dbz_quotient got %h want ffff", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 16'h1234) $display("FAIL dbz_remainder got %h want 1234", remainder); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b1) $display("FAIL dbz_flag got %0b want 1", div_by_zero); else pass_cnt++;
        repeat (5) @(posedge clk);
        #1;
        total_cnt++; if (done !== 1'b0) $display("FAIL dbz_done_drop got %0b want 0", done); else pass_cnt++;
        total_cnt++;
        if (div_by_zero !== 1'b1 || quotient !== 16'hFFFF || remainder !== 16'h1234)
            $display("FAIL dbz_hold got %0b/%h/%h want 1/ffff/1234", div_by_zero, quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        int edges;
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        while (!done && edges < 40) begin
            if (edges == 5) begin
                start = 1'b1; dividend = 16'd9; divisor = 16'd2;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
        end
        total_cnt++; if (edges !== 17) $display("FAIL ignore_latency got %0d want 17", edges); else pass_cnt++;
        total_cnt++; if (quotient !== 16'd333) $display("FAIL ignore_quotient got %0d want 333", quotient); else pass_cnt++;
        total_cnt++; if (remainder !== 16'd1) $display("FAIL ignore_remainder got %0d want 1", remainder); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int edges;
        int bc;
        int done_seen;
        @(negedge clk);
        start = 1'b1; dividend = 16'd12345; divisor = 16'd17;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 16'h0 || remainder !== 16'h0 || div_by_zero !== 1'b0)
            $display("FAIL midreset_outputs got b%0b d%0b q%h r%h z%0b want all zero",
                     busy, done, quotient, remainder, div_by_zero);
        else pass_cnt++;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        total_cnt++; if (done_seen !== 0) $display("FAIL midreset_no_done got %0d active cycles want 0", done_seen); else pass_cnt++;
        run_op(16'd50, 16'd5, edges, bc);
        total_cnt++; if (edges !== 17) $display("FAIL midreset_latency got %0d want 17", edges); else pass_cnt++;
        total_cnt++; if (quotient !== 16'd10 || remainder !== 16'd0)
            $display("FAIL midreset_result got %0d/%0d want 10/0", quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int edges;
        int bc;
        run_op(16'd100, 16'd7, edges, bc);
        total_cnt++; if (quotient !== 16'd14 || remainder !== 16'd2)
            $display("FAIL b2b_first got %0d/%0d want 14/2", quotient, remainder);
        else pass_cnt++;
        // Issued in the DONE cycle: done must drop on the start edge.
        @(negedge clk);
        start = 1'b1; dividend = 16'd65535; divisor = 16'd256;
        @(posedge clk);
        #1;
        start = 1'b0;
        total_cnt++; if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_accept got done%0b busy%0b want done0 busy1", done, busy);
        else pass_cnt++;
        total_cnt++; if (quotient !== 16'd14) $display("FAIL b2b_prev_visible got %0d want 14", quotient); else pass_cnt++;
        edges = 1;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        total_cnt++; if (edges !== 17) $display("FAIL b2b_latency got %0d want 17", edges); else pass_cnt++;
        total_cnt++; if (quotient !== 16'd255 || remainder !== 16'd255)
            $display("FAIL b2b_second got %0d/%0d want 255/255", quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] eq;
        logic [15:0] er;
        logic        ez;
        int          elat;
        int          edges;
        int          bc;
        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 16'h0000;
                1, 2:    b = 16'($urandom_range(1, 15));
                3:       b = 16'hFFFF - 16'($urandom_range(0, 3));
                default: b = 16'($urandom);
            endcase
            model(a, b, eq, er, ez, elat);
            run_op(a, b, edges, bc);
            total_cnt++;
            if (edges !== elat || quotient !== eq || remainder !== er || div_by_zero !== ez)
                $display("FAIL random%0d %h/%h got q%h r%h z%0b lat%0d want q%h r%h z%0b lat%0d",
                         n, a, b, quotient, remainder, div_by_zero, edges, eq, er, ez, elat);
            else pass_cnt++;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        test_reset();
        test_basic();
        test_full_range();
        test_div_zero();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
